sdp_be_rd_checker: RTL and testbench
====================================

// Module: sdp_be_rd_checker
// PURPOSE
//   Synthesizable read-data checker that sits directly downstream of a simple-dual-port BRAM with byte enables.
//   It snoops the write port (we/wa/wd/be) and the read address, keeps a shadow copy plus per-byte written flags,
//   and compares the BRAM's registered read data byte-by-byte one cycle after each read.
//   Used in hardware/simulation BRAM-inference regression benches alongside the formal equivalence checks.
// PARAMETERS
//   ABITS      10                  address width; shadow depth = 2**ABITS
//   DBITS      36                  data width
//   BYTEWIDTH  9                   bits per byte-enable lane; DBITS % BYTEWIDTH == 0 (elaboration error otherwise)
//   NBYTES     DBITS/BYTEWIDTH     byte-enable lanes (derived, not overridable)
//   CNTW       16                  width of the check and mismatch counters
// PORTS
//   clk              in   1         single clock, rising edge
//   rst_n            in   1         synchronous active-low reset
//   we               in   1         BRAM write enable (snooped)
//   wa               in   ABITS     BRAM write address
//   wd               in   DBITS     BRAM write data
//   be               in   NBYTES    BRAM byte enables
//   ra               in   ABITS     BRAM read address (read every cycle)
//   rd               in   DBITS     BRAM read data, 1-cycle latency from ra
//   ready            out  1         init sweep done; checking active
//   err              out  1         sticky: any mismatch since reset
//   err_pulse        out  1         1-cycle strobe per mismatching read
//   check_cnt        out  CNTW      reads that had >=1 byte lane checked (saturating)
//   mismatch_cnt     out  CNTW      reads with >=1 mismatching lane (saturating)
//   first_err_addr   out  ABITS     ra of the first mismatch
//   first_err_lanes  out  NBYTES    mismatching lanes of the first mismatch
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state<=INIT, sweep ptr<=0, ready=0, err=0, err_pulse=0, counters=0,
//     first_err_addr=0, first_err_lanes=0, pending-read valid=0. Reset mid-operation is identical; shadow data is not cleared.
//   FSM INIT: one address per cycle, clears written[ptr] (NBYTES flags) to 0; ptr increments.
//     At ptr==2**ABITS-1, the flags are cleared, then RUN; ready=1 from the next cycle. Total 2**ABITS cycles.
//     Snooped writes and reads are ignored in INIT.
//   FSM RUN (terminal until reset), write side: we=1 -> for each lane i with be[i]=1,
//     shadow[wa][i]<=wd[i], written[wa][i]<=1. Lanes with be[i]=0 are untouched. be=0 with we=1 is a no-op.
//   FSM RUN, read side, cycle N: capture ra, expected=shadow[ra], mask[i]=written[ra][i].
//     Collision: if we=1 && wa==ra, mask[i]&=~be[i]; same-cycle read-during-write lanes are never checked.
//   FSM RUN, compare at cycle N+1 on rd:
//     miss[i] = mask[i] && rd lane i != expected lane i.
//     If mask!=0, check_cnt+=1. If miss!=0: err_pulse=1, err<=1, mismatch_cnt+=1.
//     If this is the first miss since reset, first_err_addr/first_err_lanes latch; later misses do not update them.
//   Counters saturate at 2**CNTW-1; no wrap.
//   No comparison is made at the RUN entry cycle; no read is pending from INIT.
//   Shadow RAM: behavioural 2**ABITS x DBITS array with byte-lane writes and async read.
//     The checker itself need not map to BRAM.
// TESTING
//   1 Reset, then hold: ready=0 for exactly 2**ABITS cycles, then 1; err=0 and counters=0 throughout.
//   2 Write wa=5, wd=36'h123456789, be=4'hF; read ra=5 next cycle; rd=36'h123456789 the cycle after
//     -> check_cnt=1, err=0.
//   3 Write wa=7 be=4'b0011 only; read ra=7 with upper lanes garbage and lower lanes correct
//     -> check_cnt=1, err=0. Corrupt lane 0 -> err_pulse=1, first_err_lanes=4'b0001, first_err_addr=7.
//   4 Read never-written address 9 with arbitrary rd -> check_cnt unchanged, err=0.
//   5 Collision: we=1, wa=ra=3, be=4'hF, address 3 previously written -> no check that read;
//     next read of 3 expects the new data.
//   6 Force 2**CNTW+3 mismatches -> mismatch_cnt=2**CNTW-1, err=1. Assert rst_n=0 mid-stream
//     -> all outputs cleared and INIT restarts.

Source files
------------

// File: rtl/sdp_be_rd_checker.sv
// Read-data checker for a simple-dual-port byte-enable BRAM: shadows every snooped write
// and compares the BRAM's registered read data lane-by-lane one cycle after each read.
module sdp_be_rd_checker #(
  parameter int ABITS     = 10,
  parameter int DBITS     = 36,
  parameter int BYTEWIDTH = 9,
  parameter int CNTW      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [ABITS-1:0]                 wa,
  input  logic [DBITS-1:0]                 wd,
  input  logic [DBITS/BYTEWIDTH-1:0]       be,
  input  logic [ABITS-1:0]                 ra,
  input  logic [DBITS-1:0]                 rd,
  output logic                             ready,
  output logic                             err,
  output logic                             err_pulse,
  output logic [CNTW-1:0]                  check_cnt,
  output logic [CNTW-1:0]                  mismatch_cnt,
  output logic [ABITS-1:0]                 first_err_addr,
  output logic [DBITS/BYTEWIDTH-1:0]       first_err_lanes
);

  localparam int NBYTES = DBITS / BYTEWIDTH;
  localparam int DEPTH  = 1 << ABITS;

  generate
    if (DBITS % BYTEWIDTH != 0) begin : g_bad_lane_width
      $error("sdp_be_rd_checker: DBITS must be a multiple of BYTEWIDTH");
    end
  endgenerate

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              state_q, state_d;
  logic [ABITS-1:0]    ptr_q, ptr_d;

  logic [DBITS-1:0]    shadow_mem  [DEPTH];
  logic [NBYTES-1:0]   written_mem [DEPTH];

  logic [DBITS-1:0]    exp_p1_q;
  logic [NBYTES-1:0]   mask_p1_q;
  logic [ABITS-1:0]    addr_p1_q;
  logic                vld_p1_q, vld_p1_d;

  logic [NBYTES-1:0]   mask_p0;
  logic [NBYTES-1:0]   miss_p1;
  logic                chk_hit_p1, miss_hit_p1;

  logic                err_q, err_d;
  logic                err_pulse_q, err_pulse_d;
  logic [CNTW-1:0]     check_cnt_q, check_cnt_d;
  logic [CNTW-1:0]     mismatch_cnt_q, mismatch_cnt_d;
  logic [ABITS-1:0]    first_err_addr_q, first_err_addr_d;
  logic [NBYTES-1:0]   first_err_lanes_q, first_err_lanes_d;

  logic                run_wr;

  assign run_wr = rst_n && (state_q == ST_RUN) && we;

  // Sweep/run control
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Shadow contents and written flags; the sweep only touches the flags
  always_ff @(posedge clk) begin
    if (rst_n && state_q == ST_INIT) begin
      written_mem[ptr_q] <= '0;
    end else if (run_wr) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (be[i]) begin
          shadow_mem[wa][i*BYTEWIDTH +: BYTEWIDTH] <= wd[i*BYTEWIDTH +: BYTEWIDTH];
          written_mem[wa][i]                       <= 1'b1;
        end
      end
    end
  end

  // Stage p0: capture read address, expected data and the lanes worth checking.
  // Lanes written in the same cycle as the read are excluded because the BRAM's
  // read-during-write behaviour is not something this checker pins down.
  always_comb begin
    mask_p0 = written_mem[ra];
    if (we && wa == ra) mask_p0 = mask_p0 & ~be;
    vld_p1_d = (state_q == ST_RUN);
  end

  always_ff @(posedge clk) begin
    exp_p1_q  <= shadow_mem[ra];
    mask_p1_q <= mask_p0;
    addr_p1_q <= ra;
  end

  // Stage p1: compare registered BRAM output against the shadow snapshot
  always_comb begin
    for (int i = 0; i < NBYTES; i++) begin
      miss_p1[i] = mask_p1_q[i] &&
                   (rd[i*BYTEWIDTH +: BYTEWIDTH] != exp_p1_q[i*BYTEWIDTH +: BYTEWIDTH]);
    end
    chk_hit_p1  = vld_p1_q && (|mask_p1_q);
    miss_hit_p1 = vld_p1_q && (|miss_p1);

    check_cnt_d       = chk_hit_p1  ? sat_inc(check_cnt_q)    : check_cnt_q;
    mismatch_cnt_d    = miss_hit_p1 ? sat_inc(mismatch_cnt_q) : mismatch_cnt_q;
    err_d             = err_q | miss_hit_p1;
    err_pulse_d       = miss_hit_p1;
    first_err_addr_d  = first_err_addr_q;
    first_err_lanes_d = first_err_lanes_q;
    if (miss_hit_p1 && !err_q) begin
      first_err_addr_d  = addr_p1_q;
      first_err_lanes_d = miss_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_INIT;
      ptr_q             <= '0;
      vld_p1_q          <= 1'b0;
      err_q             <= 1'b0;
      err_pulse_q       <= 1'b0;
      check_cnt_q       <= '0;
      mismatch_cnt_q    <= '0;
      first_err_addr_q  <= '0;
      first_err_lanes_q <= '0;
    end else begin
      state_q           <= state_d;
      ptr_q             <= ptr_d;
      vld_p1_q          <= vld_p1_d;
      err_q             <= err_d;
      err_pulse_q       <= err_pulse_d;
      check_cnt_q       <= check_cnt_d;
      mismatch_cnt_q    <= mismatch_cnt_d;
      first_err_addr_q  <= first_err_addr_d;
      first_err_lanes_q <= first_err_lanes_d;
    end
  end

  assign ready           = (state_q == ST_RUN);
  assign err             = err_q;
  assign err_pulse       = err_pulse_q;
  assign check_cnt       = check_cnt_q;
  assign mismatch_cnt    = mismatch_cnt_q;
  assign first_err_addr  = first_err_addr_q;
  assign first_err_lanes = first_err_lanes_q;

endmodule

// File: tb/tb_sdp_be_rd_checker.sv
// Directed bench for sdp_be_rd_checker with a small shadow (16 words) and 4-bit counters.
module tb_sdp_be_rd_checker;

  localparam int ABITS  = 4;
  localparam int DBITS  = 36;
  localparam int BW     = 9;
  localparam int CNTW   = 4;
  localparam int NBYTES = DBITS / BW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              we = 1'b0;
  logic [ABITS-1:0]  wa = '0;
  logic [DBITS-1:0]  wd = '0;
  logic [NBYTES-1:0] be = '0;
  logic [ABITS-1:0]  ra = '0;
  logic [DBITS-1:0]  rd = '0;
  logic              ready, err, err_pulse;
  logic [CNTW-1:0]   check_cnt, mismatch_cnt;
  logic [ABITS-1:0]  first_err_addr;
  logic [NBYTES-1:0] first_err_lanes;

  int n_tests = 0;
  int n_fail  = 0;

  sdp_be_rd_checker #(.ABITS(ABITS), .DBITS(DBITS), .BYTEWIDTH(BW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .be(be), .ra(ra), .rd(rd),
    .ready(ready), .err(err), .err_pulse(err_pulse), .check_cnt(check_cnt),
    .mismatch_cnt(mismatch_cnt), .first_err_addr(first_err_addr),
    .first_err_lanes(first_err_lanes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iwe, input logic [ABITS-1:0] iwa, input logic [DBITS-1:0] iwd,
                      input logic [NBYTES-1:0] ibe, input logic [ABITS-1:0] ira,
                      input logic [DBITS-1:0] ird);
    we = iwe; wa = iwa; wd = iwd; be = ibe; ra = ira; rd = ird;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [ABITS-1:0] ira, input logic [DBITS-1:0] ird);
    step(1'b0, '0, '0, '0, ira, ird);
  endtask

  task automatic reset_and_sweep(input string tag);
    rst_n = 1'b0;
    idle(4'd1, '0);
    chk({tag, "_rst_ready"}, ready, 0);
    chk({tag, "_rst_err"}, err, 0);
    chk({tag, "_rst_pulse"}, err_pulse, 0);
    chk({tag, "_rst_chk"}, check_cnt, 0);
    chk({tag, "_rst_mis"}, mismatch_cnt, 0);
    chk({tag, "_rst_faddr"}, first_err_addr, 0);
    chk({tag, "_rst_flanes"}, first_err_lanes, 0);
    rst_n = 1'b1;
    for (int i = 0; i < (1 << ABITS) - 1; i++) begin
      idle('0, '0);
      chk({tag, "_init_ready"}, ready, 0);
      chk({tag, "_init_cnt"}, {err, check_cnt, mismatch_cnt}, 0);
    end
    idle('0, '0);
    chk({tag, "_ready_up"}, ready, 1);
  endtask

  localparam logic [DBITS-1:0] D5  = 36'h123456789;
  localparam logic [DBITS-1:0] W7  = 36'h876543210;
  localparam logic [DBITS-1:0] D3A = 36'h111111111;
  localparam logic [DBITS-1:0] D3B = 36'h2468ACE0F;
  localparam logic [DBITS-1:0] D1  = 36'hF0F0F0F0F;

  initial begin
    // Test 1: reset and sweep length
    reset_and_sweep("t1");

    // Test 2: full-word write then read back
    step(1'b1, 4'd5, D5, 4'hF, 4'd0, '0);
    idle(4'd5, '0);
    idle(4'd0, D5);
    chk("t2_chk", check_cnt, 1);
    chk("t2_err", err, 0);

    // Test 3a: partial write, upper lanes garbage are ignored
    step(1'b1, 4'd7, W7, 4'b0011, 4'd0, '0);
    idle(4'd7, '0);
    idle(4'd0, W7 ^ 36'hFFFFC0000);
    chk("t3a_chk", check_cnt, 2);
    chk("t3a_err", err, 0);

    // Test 4: never-written address is not checked
    idle(4'd9, '0);
    idle(4'd0, 36'hABCDEF012);
    chk("t4_chk", check_cnt, 2);
    chk("t4_pulse", err_pulse, 0);
    chk("t4_err", err, 0);

    // Test 5: read-during-write collision not checked; next read expects new data
    step(1'b1, 4'd3, D3A, 4'hF, 4'd0, '0);
    step(1'b1, 4'd3, D3B, 4'hF, 4'd3, '0);
    idle(4'd3, D3A);
    chk("t5_coll_chk", check_cnt, 2);
    chk("t5_coll_err", err, 0);
    idle(4'd0, D3B);
    chk("t5_new_chk", check_cnt, 3);
    chk("t5_new_err", err, 0);

    // Test 3b: corrupt lane 0 of address 7
    idle(4'd7, '0);
    idle(4'd0, W7 ^ 36'h1);
    chk("t3b_pulse", err_pulse, 1);
    chk("t3b_err", err, 1);
    chk("t3b_faddr", first_err_addr, 7);
    chk("t3b_flanes", first_err_lanes, 4'b0001);
    chk("t3b_mis", mismatch_cnt, 1);
    chk("t3b_chk", check_cnt, 4);
    idle(4'd0, '0);
    chk("t3b_pulse_drop", err_pulse, 0);
    chk("t3b_err_sticky", err, 1);

    // Test 6: saturate the counters with 19 mismatching reads
    step(1'b1, 4'd1, D1, 4'hF, 4'd0, '0);
    for (int j = 1; j <= 19; j++) begin
      idle(4'd1, ~D1);
      if (j == 10) begin
        chk("t6_mid_mis", mismatch_cnt, 10);
        chk("t6_mid_chk", check_cnt, 13);
      end
    end
    idle(4'd0, ~D1);
    chk("t6_mis_sat", mismatch_cnt, 15);
    chk("t6_chk_sat", check_cnt, 15);
    chk("t6_err", err, 1);
    chk("t6_pulse", err_pulse, 1);
    chk("t6_faddr_kept", first_err_addr, 7);
    chk("t6_flanes_kept", first_err_lanes, 4'b0001);

    // Mid-stream reset: outputs clear, sweep restarts, written flags forgotten
    we = 1'b0;
    reset_and_sweep("t6r");
    idle(4'd1, ~D1);
    idle(4'd0, ~D1);
    chk("t6r_unwritten_chk", check_cnt, 0);
    chk("t6r_unwritten_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
